fp32_accumulator: RTL and testbench

//  Sequential FP32 accumulator directly downstream of the FP32 multiplier in the TPU MAC path.

---
 rtl/tpu_fp_pkg.sv | 29 ++
 rtl/lzc_25.sv | 20 ++
 rtl/fp32_accumulator.sv | 203 ++++++++++++++++++++
 tb/tb_fp32_accumulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_fp_pkg.sv
// Shared FP32 definitions for the TPU MAC path.
// Holds the FP32 field widths, format constants, the packed FP32 word
// layout and the accumulator FSM state encoding.
package tpu_fp_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;   // fraction plus hidden 1

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [FP32_W-1:0] FP32_POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_OUT
    } acc_state_t;

endpackage

// File: rtl/lzc_25.sv
// 25-bit leading-zero counter, purely combinational.
// Ports:
//   value  in   25  word to scan (bit 24 is the most significant)
//   count  out  5   number of leading zeros, 25 when value is all zeros
module lzc_25 (
    input  logic [24:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd25;
        // Ascending scan: the highest set bit is written last and wins.
        for (int unsigned i = 0; i < 25; i++) begin
            if (value[i]) begin
                count = 5'(24 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_accumulator.sv
// Sequential FP32 accumulator fed by the FP32 multiplier.
// Sums a stream of products (valid/ready) into one running value and, on the
// product flagged last, presents the sum and element count downstream, then
// clears for the next dot product. Truncating arithmetic, no subnormals/NaN.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      product word valid
//   in_ready   out  1      product accepted this cycle when in_valid is high
//   in_data    in   32     FP32 product
//   in_last    in   1      product closes the current sum
//   out_valid  out  1      final sum available
//   out_ready  in   1      consumer takes the sum
//   out_data   out  32     FP32 sum
//   out_count  out  CNT_W  number of products in the sum (wraps)
module fp32_accumulator
    import tpu_fp_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state;
    acc_state_t       stateNext;

    fp32_t            acc;
    fp32_t            operand;
    logic             lastFlag;
    logic [CNT_W-1:0] count;

    // Aligned operands, registered between S_ALIGN and S_ADD.
    logic [23:0]      mantA;
    logic [23:0]      mantB;
    logic             signA;
    logic             signB;
    logic [7:0]       expA;
    logic             holdAcc;

    // ---------------- Alignment (S_ALIGN) ----------------
    logic        accZero;
    logic        opZero;
    logic [23:0] accMant;
    logic [23:0] opMant;
    logic        accIsA;
    logic [7:0]  expDiff;
    logic [23:0] smallMant;
    logic [23:0] alignedMant;

    always_comb begin
        accZero   = (acc.exp == '0);
        opZero    = (operand.exp == '0);
        accMant   = accZero ? '0 : {1'b1, acc.frac};
        opMant    = opZero  ? '0 : {1'b1, operand.frac};
        accIsA    = (acc.exp >= operand.exp);
        expDiff   = accIsA ? (acc.exp - operand.exp) : (operand.exp - acc.exp);
        smallMant = accIsA ? opMant : accMant;
        alignedMant = (expDiff >= 8'd25) ? '0 : (smallMant >> expDiff);
    end

    // ---------------- Add and normalise (S_ADD) ----------------
    logic [24:0]       sumMag;
    logic              resSign;
    logic [4:0]        leadZeros;
    logic [4:0]        normShift;
    logic [22:0]       normFrac;
    logic signed [9:0] resExp;
    fp32_t             result;

    always_comb begin
        if (signA == signB) begin
            sumMag  = {1'b0, mantA} + {1'b0, mantB};
            resSign = signA;
        end else if (mantA >= mantB) begin
            sumMag  = {1'b0, mantA} - {1'b0, mantB};
            resSign = signA;
        end else begin
            sumMag  = {1'b0, mantB} - {1'b0, mantA};
            resSign = signB;
        end
    end

    lzc_25 uLzc (
        .value (sumMag),
        .count (leadZeros)
    );

    always_comb begin
        // The 25b sum carries one guard bit above the hidden-1 position, so
        // without a carry the hidden 1 sits leadZeros-1 places too low.
        normShift = leadZeros - 5'd1;
        if (sumMag[24]) begin
            normFrac = sumMag[23:1];
            resExp   = $signed({2'b00, expA}) + 10'sd1;
        end else begin
            normFrac = 23'(sumMag << normShift);
            resExp   = $signed({2'b00, expA}) - $signed({5'b00000, normShift});
        end

        if (sumMag == '0) begin
            result = '0;
        end else if (resExp >= 10'sd255) begin
            result = {resSign, FP32_POS_INF[30:0]};
        end else if (resExp <= 10'sd0) begin
            result = '0;
        end else begin
            result = {resSign, resExp[7:0], normFrac};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_count = '0;
        unique case (state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    stateNext = S_ALIGN;
                end
            end
            S_ALIGN: stateNext = S_ADD;
            S_ADD:   stateNext = lastFlag ? S_OUT : S_IDLE;
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = acc;
                out_count = count;
                if (out_ready) begin
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            operand  <= '0;
            lastFlag <= 1'b0;
            count    <= '0;
            mantA    <= '0;
            mantB    <= '0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            expA     <= '0;
            holdAcc  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        operand  <= in_data;
                        lastFlag <= in_last;
                        count    <= count + CNT_W'(1);
                    end
                end
                S_ALIGN: begin
                    mantA   <= accIsA ? accMant : opMant;
                    mantB   <= alignedMant;
                    signA   <= accIsA ? acc.sign : operand.sign;
                    signB   <= accIsA ? operand.sign : acc.sign;
                    expA    <= accIsA ? acc.exp : operand.exp;
                    // Zero operands and a saturated sum both leave acc as is.
                    holdAcc <= opZero || (acc.exp == 8'(EXP_MAX));
                end
                S_ADD: begin
                    if (!holdAcc) begin
                        acc <= result;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accumulator.sv
module tb_fp32_accumulator;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    int unsigned checkCount = 0;
    int unsigned passCount  = 0;

    fp32_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // ---------------- Reference model ----------------
    function automatic longint alignTrunc(input longint v, input int d);
        if (d >= 25) return 0;
        if (v < 0) return -((-v) >>> d);
        return v >>> d;
    endfunction

    // One accumulation step on signed integer mantissas, truncating toward zero.
    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        longint ma, mb, s, m;
        logic   sgn;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 0) return a;
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
        mb = longint'(b[22:0]) + (longint'(1) << 23);
        if (a[31]) ma = -ma;
        if (b[31]) mb = -mb;
        if (ea >= eb) begin
            e  = ea;
            mb = alignTrunc(mb, ea - eb);
        end else begin
            e  = eb;
            ma = alignTrunc(ma, eb - ea);
        end
        s = ma + mb;
        if (s == 0) return 32'h0;
        sgn = (s < 0);
        m = sgn ? -s : s;
        if (m >= (longint'(1) << 24)) begin
            m = m >>> 1;
            e = e + 1;
        end
        while (m < (longint'(1) << 23)) begin
            m = m << 1;
            e = e - 1;
        end
        if (e >= 255) return {sgn, 31'h7F800000};
        if (e <= 0) return 32'h0;
        r = {sgn, 8'(e), 23'(m)};
        return r;
    endfunction

    function automatic logic [31:0] randFp();
        int unsigned sel;
        logic [7:0]  e;
        sel = $urandom_range(0, 19);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'($urandom_range(250, 255));
        else               e = 8'($urandom_range(110, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- Driver tasks ----------------
    task automatic sendProduct(input logic [31:0] data, input logic last);
        int unsigned waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkValue("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        checkValue("in_ready_busy", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic takeResult(input string tag, input logic [31:0] expData,
                              input logic [31:0] expCount, input int unsigned stall);
        int unsigned waitCycles = 0;
        logic [31:0] firstData;
        while (!out_valid && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!out_valid) begin
            checkValue({tag, "_out_valid_timeout"}, {31'b0, out_valid}, 32'd1);
            return;
        end
        firstData = out_data;
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clk);
            checkValue({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            checkValue({tag, "_hold_data"}, out_data, firstData);
            checkValue({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        checkValue({tag, "_data"}, out_data, expData);
        checkValue({tag, "_count"}, 32'(out_count), expCount);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkValue({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic runSum(input string tag, input logic [31:0] items[$],
                          input logic [31:0] expData, input logic [31:0] expCount,
                          input int unsigned stall);
        for (int unsigned i = 0; i < items.size(); i++) begin
            sendProduct(items[i], i == items.size() - 1);
        end
        takeResult(tag, expData, expCount, stall);
    endtask

    function automatic logic [31:0] refSum(input logic [31:0] items[$]);
        logic [31:0] a = 32'h0;
        foreach (items[i]) a = refAdd(a, items[i]);
        return a;
    endfunction

    // ---------------- Stimulus ----------------
    initial begin
        logic [31:0] items[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        checkValue("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkValue("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkValue("rst_out_data", out_data, 32'h0);
        checkValue("rst_out_count", 32'(out_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        items = '{32'h3F800000, 32'h40000000};
        runSum("one_plus_two", items, 32'h40400000, 32'd2, 0);
        items = '{32'h3FC00000, 32'hBFC00000};
        runSum("cancel", items, 32'h00000000, 32'd2, 0);
        items = '{32'h4B800000, 32'h3F800000};
        runSum("truncate", items, 32'h4B800000, 32'd2, 0);
        items = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        runSum("saturate", items, 32'h7F800000, 32'd2, 0);
        items = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF};
        runSum("sat_sticky", items, 32'h7F800000, 32'd3, 0);
        items = '{32'h00000000};
        runSum("single_zero", items, 32'h00000000, 32'd1, 0);
        items = '{32'hC0A00000};
        runSum("single_neg", items, 32'hC0A00000, 32'd1, 0);

        items = '{32'h40400000};
        runSum("backpressure", items, 32'h40400000, 32'd1, 10);
        items = '{32'h3F800000, 32'h40000000};
        runSum("after_bp", items, 32'h40400000, 32'd2, 0);

        items = {};
        for (int unsigned i = 0; i < 17; i++) items.push_back(32'h3F800000);
        runSum("count_wrap", items, 32'h41880000, 32'd1, 0);

        sendProduct(32'h3F800000, 1'b0);
        sendProduct(32'h40000000, 1'b0);
        rst_n = 1'b0;
        #1;
        checkValue("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        checkValue("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkValue("midrst_out_data", out_data, 32'h0);
        checkValue("midrst_out_count", 32'(out_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        items = '{32'h3F800000};
        runSum("after_rst", items, 32'h3F800000, 32'd1, 0);

        for (int unsigned s = 0; s < 40; s++) begin
            int unsigned n;
            n = $urandom_range(1, 64);
            items = {};
            for (int unsigned i = 0; i < n; i++) items.push_back(randFp());
            runSum($sformatf("rand%0d", s), items, refSum(items),
                   n % (32'd1 << CNT_W), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passCount, checkCount);
        $fatal(1);
    end

endmodule
